syscall_console_tx: RTL
=======================

SYSCALL_CONSOLE_TX -- requirements
Module: syscall_console_tx

Interface
REQ-001 The block SHALL have parameter BITS, default 32, meaning the width of the syscall value.
REQ-002 The block SHALL have parameter DIGITS, default 10, meaning the maximum decimal digits of a BITS-bit magnitude.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle strobe that presents a new syscall value.
REQ-006 The block SHALL have port value  input  BITS  syscall register value, sampled when start is accepted.
REQ-007 The block SHALL have port signed_mode  input  1  print value as two's complement when 1, unsigned when 0; sampled with value.
REQ-008 The block SHALL have port tx_data  output  8  ASCII byte offered to the console.
REQ-009 The block SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-010 The block SHALL have port tx_ready  input  1  console accepts tx_data this cycle.
REQ-011 The block SHALL have port busy  output  1  a conversion or transmission is in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse after the final byte transfers.
REQ-013 The block SHALL have port dropped  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-014 The FSM SHALL have states IDLE, CONVERT, SIGN, DIGIT and NEWLINE.
REQ-015 In IDLE with start=1, the block SHALL capture value and signed_mode, set busy=1 next cycle, and enter CONVERT.
REQ-016 The captured magnitude SHALL be value when signed_mode=0 or value[BITS-1]=0; otherwise it SHALL be the BITS-bit unsigned two's-complement negation, so 0x80000000 yields 2147483648.
REQ-017 CONVERT SHALL perform binary-to-BCD conversion with shift-and-add-3, one bit per cycle, for exactly BITS cycles into a 4*DIGITS-bit BCD register.
REQ-018 After CONVERT, the FSM SHALL go to SIGN if the value is negative and signed_mode=1, otherwise to DIGIT.
REQ-019 The first tx_valid SHALL assert BITS+1 cycles after the start-accept cycle.
REQ-020 SIGN SHALL offer 0x2D ('-').
REQ-021 DIGIT SHALL offer 0x30+digit, most significant first, skipping leading zeros, and SHALL emit exactly one '0' for a zero magnitude.
REQ-022 NEWLINE SHALL offer 0x0A.
REQ-023 A byte SHALL transfer only in a cycle with tx_valid=1 and tx_ready=1; the FSM or digit index SHALL advance only on transfer.
REQ-024 While tx_valid=1 and tx_ready=0, tx_data SHALL remain stable; tx_valid SHALL NOT deassert before transfer.
REQ-025 tx_valid SHALL be 0 in IDLE and CONVERT.
REQ-026 In the cycle after the NEWLINE transfer, done SHALL be 1 for one cycle, busy SHALL be 0, and the FSM SHALL be in IDLE.
REQ-027 A start arriving while busy=1 SHALL be ignored, SHALL pulse dropped the next cycle, and SHALL leave captured data unchanged.
REQ-028 A start arriving in the same cycle as done=1 SHALL be accepted, because the FSM is already in IDLE.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While reset=0, the block SHALL immediately force state=IDLE, tx_valid=0, tx_data=0x00, busy=0, done=0, dropped=0, and clear the BCD and captured registers, independent of clk.
REQ-031 A reset asserted mid-conversion or mid-transmission SHALL abort the transaction with no further bytes emitted.
REQ-032 After reset deasserts, start SHALL be honoured from the first rising clk edge.

Verification
REQ-033 The bench SHALL cover: value=0, signed_mode=0, tx_ready=1 -> bytes 0x30, 0x0A; first valid at cycle 33; done 2 cycles after.
REQ-034 The bench SHALL cover: value=1234, signed_mode=1 -> "1234\n" (0x31 0x32 0x33 0x34 0x0A).
REQ-035 The bench SHALL cover: value=0xFFFFFFFF -> "-1\n" when signed_mode=1; "4294967295\n" when signed_mode=0.
REQ-036 The bench SHALL cover: value=0x80000000, signed_mode=1, tx_ready toggled pseudo-randomly -> "-2147483648\n", with tx_data stable through every stall.
REQ-037 The bench SHALL cover: a second start during CONVERT -> dropped pulses once, and the output is still only the first value.
REQ-038 The bench SHALL cover: reset pulled low after the second digit transfers -> tx_valid=0 and busy=0 at once, and no further bytes after release.

Source files
------------

// File: rtl/syscall_console_tx_if.sv
// Byte-stream handshake between a syscall print request source and the console.
// The master side presents values and tx_ready; the slave side streams ASCII bytes and status.
interface syscall_console_tx_if #(
   parameter int BITS = 32
);
   logic            start;
   logic [BITS-1:0] value;
   logic            signed_mode;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_ready;
   logic            busy;
   logic            done;
   logic            dropped;

   modport master (
      output start, value, signed_mode, tx_ready,
      input  tx_data, tx_valid, busy, done, dropped
   );

   modport slave (
      input  start, value, signed_mode, tx_ready,
      output tx_data, tx_valid, busy, done, dropped
   );
endinterface

// File: rtl/syscall_console_tx.sv
// Prints a syscall register value as decimal ASCII followed by a newline.
// Binary-to-BCD runs one bit per cycle, then digits stream out over a valid/ready byte port.
module syscall_console_tx #(
   parameter int BITS   = 32,
   parameter int DIGITS = 10
) (
   input logic                clk,
   input logic                reset,
   syscall_console_tx_if.slave bus
);
   localparam int CNTW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BCDW = 4 * DIGITS;

   typedef enum logic [2:0] {IDLE, CONVERT, SIGN, DIGIT, NEWLINE} state_t;

   state_t          state_reg;
   logic [BCDW-1:0] bcd_reg;
   logic [BITS-1:0] shift_reg;
   logic [CNTW-1:0] cnt_reg;
   logic [IDXW-1:0] idx_reg;
   logic            neg_reg;
   logic [7:0]      tx_data_reg;
   logic            tx_valid_reg;
   logic            busy_reg;
   logic            done_reg;
   logic            dropped_reg;

   logic [BCDW-1:0] bcd_adj;
   logic [BCDW-1:0] bcd_next;
   logic [IDXW-1:0] lead_next;
   logic [IDXW-1:0] idx_dec;
   logic            is_neg;
   logic [BITS-1:0] magnitude;

   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return {4'h3, d};
   endfunction

   // Add-3 correction on every BCD digit before the shift.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end
   endgenerate

   assign bcd_next  = {bcd_adj[BCDW-2:0], shift_reg[BITS-1]};
   assign idx_dec   = idx_reg - 1'b1;
   assign is_neg    = bus.signed_mode & bus.value[BITS-1];
   assign magnitude = is_neg ? (~bus.value + {{(BITS-1){1'b0}}, 1'b1}) : bus.value;

   // Highest non-zero digit; a zero magnitude falls through to index 0 so one '0' prints.
   always_comb begin
      lead_next = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_next[4*i +: 4] != 4'd0) lead_next = IDXW'(i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         bcd_reg      <= '0;
         shift_reg    <= '0;
         cnt_reg      <= '0;
         idx_reg      <= '0;
         neg_reg      <= 1'b0;
         tx_data_reg  <= 8'h00;
         tx_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         dropped_reg  <= 1'b0;
      end else begin
         done_reg    <= 1'b0;
         dropped_reg <= bus.start && (state_reg != IDLE);
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  shift_reg <= magnitude;
                  neg_reg   <= is_neg;
                  bcd_reg   <= '0;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= CONVERT;
               end
            end
            CONVERT: begin
               bcd_reg   <= bcd_next;
               shift_reg <= {shift_reg[BITS-2:0], 1'b0};
               cnt_reg   <= cnt_reg + 1'b1;
               // The first byte is registered on the last shift so it is valid BITS+1 cycles after start.
               if (cnt_reg == CNTW'(BITS - 1)) begin
                  idx_reg      <= lead_next;
                  tx_valid_reg <= 1'b1;
                  if (neg_reg) begin
                     state_reg   <= SIGN;
                     tx_data_reg <= 8'h2D;
                  end else begin
                     state_reg   <= DIGIT;
                     tx_data_reg <= ascii_digit(bcd_next[4*lead_next +: 4]);
                  end
               end
            end
            SIGN: begin
               if (bus.tx_ready) begin
                  state_reg   <= DIGIT;
                  tx_data_reg <= ascii_digit(bcd_reg[4*idx_reg +: 4]);
               end
            end
            DIGIT: begin
               if (bus.tx_ready) begin
                  if (idx_reg == '0) begin
                     state_reg   <= NEWLINE;
                     tx_data_reg <= 8'h0A;
                  end else begin
                     idx_reg     <= idx_dec;
                     tx_data_reg <= ascii_digit(bcd_reg[4*idx_dec +: 4]);
                  end
               end
            end
            NEWLINE: begin
               if (bus.tx_ready) begin
                  state_reg    <= IDLE;
                  tx_valid_reg <= 1'b0;
                  tx_data_reg  <= 8'h00;
                  busy_reg     <= 1'b0;
                  done_reg     <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.tx_data  = tx_data_reg;
   assign bus.tx_valid = tx_valid_reg;
   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.dropped  = dropped_reg;
endmodule
